// File: rtl/clmul_seq.sv
// Multi-cycle carry-less multiplier (clmul / clmulh / clmulr), STEP multiplier bits per cycle.
// Optional early termination on an exhausted multiplier: define CLMUL_SEQ_EARLYOUT_EN.
module clmul_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Funct3,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy,
  output logic [WIDTH-1:0] Result
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a transfer happens on an edge where valid and ready are both high
  // and Flush is low; valid-side payload must be stable while valid waits on ready.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state, state_nx;
  logic [2*WIDTH-1:0]  areg, acc, acc_step;
  logic [WIDTH-1:0]    breg, breg_shift;
  logic [CW-1:0]       count;
  logic [2:0]          opreg;
  logic                last;

  always_comb begin
    acc_step = acc;
    for (int i = 0; i < STEP; i++) begin
      if (breg[i]) acc_step = acc_step ^ (areg << i);
    end
  end

  assign breg_shift = breg >> STEP;

`ifdef CLMUL_SEQ_EARLYOUT_EN
  assign last = (count == CW'(N - 1)) || (breg_shift == '0);
`else
  assign last = (count == CW'(N - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    InReady  = 1'b0;
    OutValid = 1'b0;
    Busy     = 1'b0;
    case (state)
      S_IDLE: begin
        InReady = 1'b1;
        if (InValid) state_nx = S_BUSY;
      end
      S_BUSY: begin
        Busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        if (OutReady) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (Flush) state_nx = S_IDLE;
  end

  // Flush only redirects the FSM; datapath registers keep their contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      areg  <= '0;
      breg  <= '0;
      acc   <= '0;
      count <= '0;
      opreg <= '0;
    end else if (!Flush) begin
      if (state == S_IDLE && InValid) begin
        areg  <= {{WIDTH{1'b0}}, A};
        breg  <= B;
        acc   <= '0;
        count <= '0;
        opreg <= Funct3;
      end else if (state == S_BUSY) begin
        acc   <= acc_step;
        areg  <= areg << STEP;
        breg  <= breg_shift;
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    case (opreg)
      3'b001:  Result = acc[WIDTH-1:0];
      3'b011:  Result = acc[2*WIDTH-1:WIDTH];
      3'b010:  Result = acc[2*WIDTH-2:WIDTH-1];
      default: Result = '0;
    endcase
  end

endmodule

// File: tb/tb_clmul_seq.sv
// Bench for clmul_seq: directed scenarios plus random operations against a product model.
module tb_clmul_seq;

  localparam int W    = 32;
  localparam int STEP = 4;
  localparam int N    = W / STEP;

  logic         clk, reset;
  logic         InValid, InReady, Flush, OutValid, OutReady, Busy;
  logic [W-1:0] A, B, Result;
  logic [2:0]   Funct3;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  clmul_seq #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Funct3(Funct3), .Flush(Flush), .OutValid(OutValid),
    .OutReady(OutReady), .Busy(Busy), .Result(Result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [2*W-1:0] clmul_full(logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    return p;
  endfunction

  function automatic logic [W-1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] f);
    logic [2*W-1:0] p;
    p = clmul_full(a, b);
    case (f)
      3'b001:  return p[W-1:0];
      3'b011:  return p[2*W-1:W];
      3'b010:  return p[2*W-2:W-1];
      default: return '0;
    endcase
  endfunction

  function automatic int exp_lat(logic [W-1:0] b);
`ifdef CLMUL_SEQ_EARLYOUT_EN
    int msb;
    if (b == '0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    return (msb + STEP) / STEP;
`else
    return N;
`endif
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: push at accept, compare every DONE cycle, pop at output handshake
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("inready_vs_busy", W'(InReady), W'(!Busy));
      if (OutValid) begin
        check("busy_in_done", W'(Busy), W'(1));
        if (exp_q.size() == 0) check("unexpected_outvalid", W'(OutValid), W'(0));
        else                   check("result", Result, exp_q[0]);
      end
      if (Flush) begin
        exp_q.delete();
      end else begin
        if (OutValid && OutReady && exp_q.size() != 0) void'(exp_q.pop_front());
        if (InValid && InReady) exp_q.push_back(model(A, B, Funct3));
      end
    end
  end

  // driver tasks (called at posedge+#1)
  task automatic start_op(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] f);
    int guard;
    InValid = 1'b1; A = a; B = b; Funct3 = f;
    guard = 0;
    @(negedge clk);
    while (!InReady && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) check("accept_timeout", W'(InReady), W'(1));
    @(posedge clk); #1;
    InValid = 1'b0;
    A = $urandom; B = $urandom; Funct3 = 3'($urandom);
  endtask

  task automatic wait_valid(int lat_exp);
    int lat;
    lat = 0;
    while (!OutValid && lat < 200) begin @(posedge clk); #1; lat++; end
    check("latency", W'(lat), W'(lat_exp));
  endtask

  task automatic finish_op(int hold);
    if (hold > 0) begin
      OutReady = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_outvalid", W'(OutValid), W'(1));
        check("hold_inready", W'(InReady), W'(0));
      end
      OutReady = 1'b1;
    end
    @(posedge clk); #1;
    check("after_hs_outvalid", W'(OutValid), W'(0));
    check("after_hs_inready", W'(InReady), W'(1));
  endtask

  task automatic run_lit(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] f, logic [W-1:0] lit);
    start_op(a, b, f);
    wait_valid(exp_lat(b));
    check("literal", Result, lit);
    finish_op(0);
  endtask

  task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] f, int hold);
    logic [W-1:0] bb;
    bb = b;
    start_op(a, b, f);
    wait_valid(exp_lat(bb));
    finish_op(hold);
  endtask

  initial begin
    reset = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    A = '0; B = '0; Funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", Result, '0);
    check("rst_outvalid", W'(OutValid), W'(0));
    check("rst_busy", W'(Busy), W'(0));
    check("rst_inready", W'(InReady), W'(1));
    reset = 1'b0;
    @(posedge clk); #1;

    // directed literals that pin the model
    run_lit(32'h0000_0003, 32'h0000_0003, 3'b001, 32'h0000_0005);
    run_lit(32'h8000_0000, 32'h8000_0000, 3'b011, 32'h4000_0000);
    run_lit(32'h8000_0000, 32'h8000_0000, 3'b001, 32'h0000_0000);
    run_lit(32'h8000_0000, 32'h0000_0002, 3'b010, 32'h0000_0002);
    run_lit(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 32'h5555_5555);
    run_lit(32'h0000_1234, 32'h0000_0001, 3'b001, 32'h0000_1234);
    run_lit(32'hDEAD_BEEF, 32'h0000_0000, 3'b011, 32'h0000_0000);
    run_lit(32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 32'h0000_0000);

    // backpressure, with a new request waiting during the hold
    start_op(32'h3, 32'h3, 3'b001);
    wait_valid(exp_lat(32'h3));
    OutReady = 1'b0;
    InValid = 1'b1; A = 32'h3; B = 32'h3; Funct3 = 3'b001;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_outvalid", W'(OutValid), W'(1));
      check("bp_result", Result, 32'h5);
      check("bp_inready", W'(InReady), W'(0));
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_busy", W'(Busy), W'(0));
    check("bp_hs_inready", W'(InReady), W'(1));
    @(posedge clk); #1;
    check("bp_next_accept", W'(Busy), W'(1));
    InValid = 1'b0;
    wait_valid(exp_lat(32'h3));
    check("bp_second", Result, 32'h5);
    finish_op(0);

    // flush in BUSY cycle 4
    start_op(32'hCAFE_F00D, 32'hFFFF_FFFF, 3'b011);
    repeat (3) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush_busy", W'(Busy), W'(0));
    check("flush_inready", W'(InReady), W'(1));
    repeat (N + 2) begin
      @(posedge clk); #1;
      check("flush_no_valid", W'(OutValid), W'(0));
    end
    run_lit(32'h3, 32'h3, 3'b001, 32'h5);
    InValid = 1'b1; Flush = 1'b1; A = 32'h7; B = 32'h7; Funct3 = 3'b001;
    @(posedge clk); #1;
    InValid = 1'b0; Flush = 1'b0;
    check("flush_vs_invalid", W'(Busy), W'(0));

    // asynchronous reset in BUSY cycle 3
    start_op(32'hFFFF_0000, 32'h0F0F_0F0F, 3'b011);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_outvalid", W'(OutValid), W'(0));
    check("arst_busy", W'(Busy), W'(0));
    check("arst_result", Result, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // random operations
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rf;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0: rf = 3'b001;
        1: rf = 3'b011;
        2: rf = 3'b010;
        default: rf = 3'($urandom);
      endcase
      run_op(ra, rb, rf, $urandom_range(0, 3));
    end

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
